// File: rtl/adpcm_ram_arb_pkg.sv
// Shared PC-88 sound definitions: ADPCM RAM address width and the
// ADPCM RAM arbiter state encoding.
package pc88_snd_pkg;

    localparam int ADPCM_AW = 18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPN_WR = 2'd1,
        ST_OPN_RD = 2'd2,
        ST_HOST   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/adpcm_ram_arb_if.sv
// Bus bundle around the ADPCM RAM arbiter: OPNA side, host side and RAM side.
interface adpcm_ram_arb_if
    import pc88_snd_pkg::*;
#(
    parameter int AW = ADPCM_AW
) ();

    logic [AW-1:0] adpcm_addr;
    logic          adpcm_roe;
    logic          adpcm_wr;
    logic [7:0]    adpcm_dout;
    logic [7:0]    adpcm_din;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          host_ack;
    logic [7:0]    host_rdata;

    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          mem_ready;

    logic          busy;
    logic          ovf;
    logic          ovf_clr;

    // Arbiter side.
    modport slave (
        input  adpcm_addr, adpcm_roe, adpcm_wr, adpcm_dout,
        input  host_req, host_we, host_addr, host_wdata,
        input  mem_rdata, mem_ready, ovf_clr,
        output adpcm_din, host_ack, host_rdata,
        output mem_cs, mem_we, mem_addr, mem_wdata, busy, ovf
    );

    // Environment side (OPNA, host and RAM together).
    modport master (
        output adpcm_addr, adpcm_roe, adpcm_wr, adpcm_dout,
        output host_req, host_we, host_addr, host_wdata,
        output mem_rdata, mem_ready, ovf_clr,
        input  adpcm_din, host_ack, host_rdata,
        input  mem_cs, mem_we, mem_addr, mem_wdata, busy, ovf
    );

endinterface

// File: rtl/adpcm_ram_arb_req_cap.sv
// Rising-edge detect on an OPNA strobe plus a one-deep pending request slot.
module adpcm_req_cap
    import pc88_snd_pkg::*;
#(
    parameter int W = ADPCM_AW
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         lvl_i,
    input  logic [W-1:0] pld_i,
    input  logic         done_i,
    output logic         req_o,
    output logic [W-1:0] pld_o,
    output logic         ovr_o
);

    logic         lvl_q;
    logic         pend_q, pend_d;
    logic [W-1:0] pld_q, pld_d;
    logic         edge_s;

    assign edge_s = lvl_i & ~lvl_q;

    // A fresh edge wins over completion: the new request stays pending.
    always_comb begin
        pend_d = pend_q;
        pld_d  = pld_q;
        if (edge_s) begin
            pend_d = 1'b1;
            pld_d  = pld_i;
        end else if (done_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q  <= 1'b0;
            pend_q <= 1'b0;
            pld_q  <= '0;
        end else begin
            lvl_q  <= lvl_i;
            pend_q <= pend_d;
            pld_q  <= pld_d;
        end
    end

    // The edge cycle itself already requests, so a grant can follow immediately.
    assign req_o = pend_q | edge_s;
    assign pld_o = edge_s ? pld_i : pld_q;
    assign ovr_o = edge_s & pend_q & ~done_i;

endmodule

// File: rtl/adpcm_ram_arb.sv
// ADPCM RAM arbiter: shares one byte-wide RAM between OPNA ADPCM-B and a host,
// with OPN priority and a starvation guard for the host.
module adpcm_ram_arb
    import pc88_snd_pkg::*;
#(
    parameter int AW     = ADPCM_AW,
    parameter int STARVE = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    adpcm_ram_arb_if.slave  bus
);

    localparam int SW = $clog2(STARVE + 1);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    din_q, din_d;
    logic [7:0]    hrdata_q, hrdata_d;
    logic          hack_q, hack_d;
    logic          ovf_q, ovf_d;

    logic          rd_req, wr_req, rd_ovr, wr_ovr;
    logic [AW-1:0] rd_addr;
    logic [AW+7:0] wr_pld;
    logic          done, rd_done, wr_done;
    logic          starve_max, host_win, grant_opn, grant_host;

    assign done    = (state_q != ST_IDLE) && bus.mem_ready;
    assign rd_done = done && (state_q == ST_OPN_RD);
    assign wr_done = done && (state_q == ST_OPN_WR);

    adpcm_req_cap #(.W(AW)) u_rd_cap (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (bus.adpcm_roe),
        .pld_i  (bus.adpcm_addr),
        .done_i (rd_done),
        .req_o  (rd_req),
        .pld_o  (rd_addr),
        .ovr_o  (rd_ovr)
    );

    adpcm_req_cap #(.W(AW + 8)) u_wr_cap (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (bus.adpcm_wr),
        .pld_i  ({bus.adpcm_addr, bus.adpcm_dout}),
        .done_i (wr_done),
        .req_o  (wr_req),
        .pld_o  (wr_pld),
        .ovr_o  (wr_ovr)
    );

    assign starve_max = (starve_q == SW'(STARVE));
    // Host wins when nothing from OPN is waiting, or when it has waited too long.
    assign host_win   = bus.host_req && (starve_max || (!wr_req && !rd_req));

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        din_d      = din_q;
        hrdata_d   = hrdata_q;
        hack_d     = 1'b0;
        ovf_d      = ovf_q;
        grant_opn  = 1'b0;
        grant_host = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (host_win) begin
                    state_d    = ST_HOST;
                    addr_d     = bus.host_addr;
                    we_d       = bus.host_we;
                    wdata_d    = bus.host_wdata;
                    grant_host = 1'b1;
                end else if (wr_req) begin
                    state_d   = ST_OPN_WR;
                    addr_d    = wr_pld[AW+7:8];
                    we_d      = 1'b1;
                    wdata_d   = wr_pld[7:0];
                    grant_opn = 1'b1;
                end else if (rd_req) begin
                    state_d   = ST_OPN_RD;
                    addr_d    = rd_addr;
                    we_d      = 1'b0;
                    grant_opn = 1'b1;
                end
            end
            default: begin
                if (bus.mem_ready) state_d = ST_IDLE;
            end
        endcase

        if (!bus.host_req || grant_host)
            starve_d = '0;
        else if (grant_opn && !starve_max)
            starve_d = starve_q + 1'b1;

        if (rd_done) din_d = bus.mem_rdata;
        if (done && state_q == ST_HOST) begin
            hack_d = 1'b1;
            if (!we_q) hrdata_d = bus.mem_rdata;
        end

        if (rd_ovr || wr_ovr)
            ovf_d = 1'b1;
        else if (bus.ovf_clr)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            din_q    <= '0;
            hrdata_q <= '0;
            hack_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            din_q    <= din_d;
            hrdata_q <= hrdata_d;
            hack_q   <= hack_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.mem_cs     = (state_q != ST_IDLE);
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.mem_we     = we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.adpcm_din  = din_q;
    assign bus.host_rdata = hrdata_q;
    assign bus.host_ack   = hack_q;
    assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_adpcm_ram_arb.sv
// Bench for adpcm_ram_arb: directed scenarios plus a randomized op stream
// checked against a byte-array memory model and the grant-priority rules.
module tb_adpcm_ram_arb;
    import pc88_snd_pkg::*;

    localparam int AW = 18;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
    } acc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adpcm_ram_arb_if #(.AW(AW)) bus ();

    adpcm_ram_arb #(.AW(AW), .STARVE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // RAM model with programmable wait states
    logic [7:0]    ram [0:(1<<AW)-1];
    int            waits = 0;
    int            wcnt;
    acc_t          log_q[$];
    int            acks = 0, gap_err = 0, stab_err = 0;
    logic          done_q = 1'b0, prev_cs = 1'b0, prev_we = 1'b0;
    logic [AW-1:0] prev_addr = '0;
    logic [7:0]    prev_wdata = '0;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [7:0]    bd_data = '0;

    assign bus.mem_ready = bus.mem_cs && (wcnt == waits);
    assign bus.mem_rdata = ram[bus.mem_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (bus.mem_cs && !bus.mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        if (rst_n && bus.mem_cs && bus.mem_ready) begin
            log_q.push_back('{we: bus.mem_we, addr: bus.mem_addr});
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        end
        if (rst_n && bus.host_ack) acks <= acks + 1;
        if (rst_n && done_q && bus.mem_cs) gap_err <= gap_err + 1;
        if (rst_n && prev_cs && bus.mem_cs &&
            (bus.mem_addr !== prev_addr || bus.mem_we !== prev_we || bus.mem_wdata !== prev_wdata))
            stab_err <= stab_err + 1;
        done_q     <= rst_n && bus.mem_cs && bus.mem_ready;
        prev_cs    <= rst_n && bus.mem_cs;
        prev_addr  <= bus.mem_addr;
        prev_we    <= bus.mem_we;
        prev_wdata <= bus.mem_wdata;
    end

    logic [7:0] mdl [int];
    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bd(input logic [AW-1:0] a, input logic [7:0] d);
        bd_addr = a; bd_data = d; bd_we = 1'b1;
        tick;
        bd_we = 1'b0;
        mdl[int'(a)] = d;
    endtask

    task automatic opn_op(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                          output logic [7:0] rd);
        int s0;
        int n;
        s0 = log_q.size();
        n = 0;
        bus.adpcm_addr = a;
        bus.adpcm_dout = d;
        if (we) bus.adpcm_wr = 1'b1; else bus.adpcm_roe = 1'b1;
        tick;
        bus.adpcm_wr = 1'b0;
        bus.adpcm_roe = 1'b0;
        while (log_q.size() == s0 && n < 40) begin tick; n++; end
        chk("opn_done", 32'(log_q.size() > s0), 1);
        rd = bus.adpcm_din;
    endtask

    task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                           output logic [7:0] rd);
        int n;
        n = 0;
        bus.host_we = we; bus.host_addr = a; bus.host_wdata = d; bus.host_req = 1'b1;
        while (!bus.host_ack && n < 60) begin tick; n++; end
        chk("host_ack", bus.host_ack, 1);
        rd = bus.host_rdata;
        bus.host_req = 1'b0;
        tick;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0]    r1, r2;
        logic [AW-1:0] pool [8];
        logic [AW-1:0] a, b;
        logic [7:0]    d;
        int            s0, a0, k, hidx;

        bus.adpcm_addr = '0; bus.adpcm_roe = 1'b0; bus.adpcm_wr = 1'b0; bus.adpcm_dout = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.ovf_clr = 1'b0;

        // reset state
        #3;
        chk("rst_cs", bus.mem_cs, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_din", bus.adpcm_din, 0);
        chk("rst_ack", bus.host_ack, 0);
        chk("rst_hrdata", bus.host_rdata, 0);
        chk("rst_maddr", bus.mem_addr, 0);
        chk("rst_mwe", bus.mem_we, 0);
        chk("rst_mwdata", bus.mem_wdata, 0);
        tick;
        rst_n = 1'b1;
        tick;

        // OPN read latency with zero-wait RAM
        waits = 0;
        bd(18'h12345, 8'hA5);
        bus.adpcm_addr = 18'h12345; bus.adpcm_roe = 1'b1;
        chk("lat_t_cs", bus.mem_cs, 0);
        tick;
        bus.adpcm_roe = 1'b0;
        chk("lat_t1_cs", bus.mem_cs, 1);
        chk("lat_t1_addr", bus.mem_addr, 32'h12345);
        chk("lat_t1_we", bus.mem_we, 0);
        chk("lat_t1_busy", bus.busy, 1);
        tick;
        chk("lat_t2_din", bus.adpcm_din, 8'hA5);
        chk("lat_t2_cs", bus.mem_cs, 0);
        chk("lat_t2_ovf", bus.ovf, 0);

        // write and read both pending at one IDLE: write goes first
        waits = 3;
        bd(18'h00011, 8'h96);
        s0 = log_q.size();
        bus.host_we = 1'b0; bus.host_addr = 18'h02000; bus.host_req = 1'b1;
        tick;
        bus.adpcm_addr = 18'h00010; bus.adpcm_dout = 8'h5A; bus.adpcm_wr = 1'b1;
        tick;
        bus.adpcm_wr = 1'b0; bus.adpcm_addr = 18'h00011; bus.adpcm_roe = 1'b1;
        tick;
        bus.adpcm_roe = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (bus.host_ack) bus.host_req = 1'b0;
            if (log_q.size() >= s0 + 3) break;
            tick;
        end
        mdl[32'h10] = 8'h5A;
        chk("sim_cnt", log_q.size(), s0 + 3);
        if (log_q.size() >= s0 + 3) begin
            chk("sim_first", {log_q[s0+1].we, log_q[s0+1].addr}, {1'b1, 18'h00010});
            chk("sim_second", {log_q[s0+2].we, log_q[s0+2].addr}, {1'b0, 18'h00011});
        end
        chk("sim_din", bus.adpcm_din, 8'h96);
        chk("sim_ovf", bus.ovf, 0);
        host_op(1'b0, 18'h00010, 8'h00, r1);
        chk("sim_wr_data", r1, 8'h5A);

        // overrun: two read edges while the RAM is busy with a write
        waits = 3;
        bd(18'h00300, 8'h3C);
        bd(18'h00301, 8'hC3);
        s0 = log_q.size();
        bus.adpcm_addr = 18'h00200; bus.adpcm_dout = 8'h77; bus.adpcm_wr = 1'b1;
        tick;
        bus.adpcm_wr = 1'b0; bus.adpcm_addr = 18'h00300; bus.adpcm_roe = 1'b1;
        tick;
        bus.adpcm_roe = 1'b0;
        tick;
        bus.adpcm_addr = 18'h00301; bus.adpcm_roe = 1'b1;
        tick;
        bus.adpcm_roe = 1'b0;
        chk("ovr_flag", bus.ovf, 1);
        for (int n = 0; n < 40 && log_q.size() < s0 + 2; n++) tick;
        mdl[32'h200] = 8'h77;
        repeat (6) tick;
        chk("ovr_cnt", log_q.size(), s0 + 2);
        if (log_q.size() >= s0 + 2)
            chk("ovr_addr", {log_q[s0+1].we, log_q[s0+1].addr}, {1'b0, 18'h00301});
        chk("ovr_din", bus.adpcm_din, 8'hC3);
        chk("ovr_sticky", bus.ovf, 1);
        bus.ovf_clr = 1'b1;
        tick;
        bus.ovf_clr = 1'b0;
        chk("ovr_clr", bus.ovf, 0);

        // starvation guard: host waits behind at most 4 OPN grants
        waits = 0;
        s0 = log_q.size();
        a0 = acks;
        bus.host_we = 1'b0; bus.host_addr = 18'h3F000; bus.host_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.adpcm_addr = 18'h00100 + AW'(i); bus.adpcm_roe = 1'b1;
            tick;
            bus.adpcm_roe = 1'b0;
            if (bus.host_ack) bus.host_req = 1'b0;
            tick;
        end
        for (int n = 0; n < 20; n++) begin
            if (bus.host_ack) bus.host_req = 1'b0;
            tick;
        end
        hidx = -1;
        for (int i = s0; i < log_q.size(); i++)
            if (hidx < 0 && log_q[i].addr == 18'h3F000) hidx = i - s0;
        chk("stv_idx", hidx, 4);
        chk("stv_total", log_q.size(), s0 + 6);
        chk("stv_acks", acks - a0, 1);
        chk("stv_ovf", bus.ovf, 0);

        // host round trip at the top address
        a0 = acks;
        host_op(1'b1, 18'h3FFFF, 8'h3C, r1);
        host_op(1'b0, 18'h3FFFF, 8'h00, r1);
        mdl[32'h3FFFF] = 8'h3C;
        chk("host_rt", r1, 8'h3C);
        chk("host_rt_acks", acks - a0, 2);

        // random op stream against the memory model
        for (int i = 0; i < 8; i++) begin
            pool[i] = AW'($urandom_range(0, (1 << AW) - 1));
            d = 8'($urandom);
            waits = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) host_op(1'b1, pool[i], d, r1);
            else opn_op(1'b1, pool[i], d, r1);
            mdl[int'(pool[i])] = d;
        end
        for (int i = 0; i < 40; i++) begin
            waits = $urandom_range(0, 3);
            k = $urandom_range(0, 4);
            a = pool[$urandom_range(0, 7)];
            d = 8'($urandom);
            case (k)
                0: begin
                    opn_op(1'b1, a, d, r1);
                    mdl[int'(a)] = d;
                    chk("rnd_opn_wr", {log_q[log_q.size()-1].we, log_q[log_q.size()-1].addr}, {1'b1, a});
                end
                1: begin
                    opn_op(1'b0, a, 8'h00, r1);
                    chk("rnd_opn_rd", r1, mdl[int'(a)]);
                end
                2: begin
                    host_op(1'b1, a, d, r1);
                    mdl[int'(a)] = d;
                end
                3: begin
                    host_op(1'b0, a, 8'h00, r1);
                    chk("rnd_host_rd", r1, mdl[int'(a)]);
                end
                default: begin
                    b = pool[(i + 3) % 8];
                    fork
                        opn_op(1'b0, a, 8'h00, r1);
                        host_op(1'b0, b, 8'h00, r2);
                    join
                    chk("rnd_race_opn", r1, mdl[int'(a)]);
                    chk("rnd_race_host", r2, mdl[int'(b)]);
                    chk("rnd_race_order", log_q[log_q.size()-2].addr, a);
                end
            endcase
        end
        chk("rnd_gap", gap_err, 0);
        chk("rnd_stable", stab_err, 0);
        chk("rnd_ovf", bus.ovf, 0);

        // reset in the middle of a 5-wait host read
        waits = 0;
        opn_op(1'b0, 18'h12345, 8'h00, r1);
        chk("pre_rst_din", r1, 8'hA5);
        waits = 5;
        s0 = log_q.size();
        a0 = acks;
        bus.host_we = 1'b0; bus.host_addr = 18'h0ABCD; bus.host_req = 1'b1;
        for (int n = 0; n < 10 && !bus.mem_cs; n++) tick;
        chk("mid_cs", bus.mem_cs, 1);
        tick;
        tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cs", bus.mem_cs, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_din", bus.adpcm_din, 0);
        bus.host_req = 1'b0;
        repeat (3) tick;
        rst_n = 1'b1;
        repeat (3) tick;
        chk("post_rst_acks", acks - a0, 0);
        chk("post_rst_log", log_q.size(), s0);
        chk("post_rst_din", bus.adpcm_din, 0);
        chk("post_rst_cs", bus.mem_cs, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
